// File: rtl/pixel_plot_sink.sv
// Framebuffer write sink: clips signed points to the raster, queues linear addresses, issues acked writes.
// Optional PLOT_CLIP_COUNT_EN builds a saturating counter of clipped points on clip_count.
`timescale 1ns/1ps
module pixel_plot_sink #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int COORD_W    = 32,
    parameter int COLOR_W    = 4,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] in_x,
    input  logic signed [COORD_W-1:0] in_y,
    input  logic        [COLOR_W-1:0] in_color,
    output logic        [ADDR_W-1:0]  mem_addr,
    output logic        [COLOR_W-1:0] mem_wdata,
    output logic                      mem_we,
    input  logic                      mem_ack,
    output logic                      busy,
    output logic        [15:0]        clip_count,
    output logic                      dbg_state_o
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + COLOR_W;
    localparam logic signed [COORD_W-1:0] H_LIM = COORD_W'(H_RES);
    localparam logic signed [COORD_W-1:0] V_LIM = COORD_W'(V_RES);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ENTRY_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [COLOR_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                 fifo_full, fifo_empty;
    logic                 accept, clipped, push, pop;
    logic [ADDR_W-1:0]    lin_addr;
    logic [ENTRY_W-1:0]   head;

    // Handshake: a point transfers on any rising edge where in_valid && in_ready.
    // in_ready depends only on registered FIFO occupancy, so a same-cycle pop never frees room.
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign in_ready   = !reset && !fifo_full;
    assign accept     = in_valid && in_ready;

    assign clipped  = in_x[COORD_W-1] || (in_x >= H_LIM) || in_y[COORD_W-1] || (in_y >= V_LIM);
    assign lin_addr = in_y[ADDR_W-1:0] * ADDR_W'(H_RES) + in_x[ADDR_W-1:0];
    assign push     = accept && !clipped;
    assign head     = fifo_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {lin_addr, in_color};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address and data stay frozen until the memory acknowledges.
                if (mem_ack) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            mem_addr_d  = head[ENTRY_W-1:COLOR_W];
            mem_wdata_d = head[COLOR_W-1:0];
        end
    end

    assign mem_we      = (state_q == S_WRITE);
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = !fifo_empty || (state_q == S_WRITE);
    assign dbg_state_o = state_q;

`ifdef PLOT_CLIP_COUNT_EN
    logic [15:0] clip_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clip_cnt_q <= '0;
        end else if (accept && clipped && (clip_cnt_q != 16'hFFFF)) begin
            clip_cnt_q <= clip_cnt_q + 16'd1;
        end
    end

    assign clip_count = clip_cnt_q;
`else
    assign clip_count = 16'd0;
`endif

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Directed bench for pixel_plot_sink: reset, single write, clipping, corners, backpressure, late ack, mid-write reset.
`timescale 1ns/1ps
module tb_pixel_plot_sink;

  localparam int COORD_W = 32;
  localparam int COLOR_W = 4;
  localparam int ADDR_W  = 19;
  localparam int ENT_W   = ADDR_W + COLOR_W;

  logic                      clk;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [COORD_W-1:0] in_x;
  logic signed [COORD_W-1:0] in_y;
  logic        [COLOR_W-1:0] in_color;
  logic        [ADDR_W-1:0]  mem_addr;
  logic        [COLOR_W-1:0] mem_wdata;
  logic                      mem_we;
  logic                      mem_ack;
  logic                      busy;
  logic        [15:0]        clip_count;
  logic                      dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [ENT_W-1:0] exp_q[$];
  logic [ENT_W-1:0] wr_log[$];

`ifdef PLOT_CLIP_COUNT_EN
  localparam logic [15:0] EXP_CLIPS = 16'd3;
`else
  localparam logic [15:0] EXP_CLIPS = 16'd0;
`endif

  pixel_plot_sink dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_color    (in_color),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack),
    .busy        (busy),
    .clip_count  (clip_count),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // write monitor: a write completes at the posedge following a negedge with we && ack
  always @(negedge clk) begin
    if (mem_we && mem_ack) wr_log.push_back({mem_addr, mem_wdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present one point, return 1 ns after the accepting edge
  task automatic send(input int x, input int y, input logic [COLOR_W-1:0] c);
    int n;
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    in_color = c;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1 for point (%0d,%0d)", in_ready, x, y);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_log(input string name);
    checks++;
    if (wr_log.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d writes required %0d", name, wr_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (wr_log[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_entry%0d: got addr=%0d data=%h required addr=%0d data=%h", name, i,
                   wr_log[i][ENT_W-1:COLOR_W], wr_log[i][COLOR_W-1:0],
                   exp_q[i][ENT_W-1:COLOR_W], exp_q[i][COLOR_W-1:0]);
        end
      end
    end
    wr_log.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if ({in_ready, mem_we, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: ready/we/busy=%b required 000", {in_ready, mem_we, busy});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || clip_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs: addr=%0d data=%h clips=%0d required 0 0 0", mem_addr, mem_wdata, clip_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
    tick();
  endtask

  task automatic test_single();
    mem_ack = 1'b1;
    send(10, 5, 4'hA);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL single_early_we: mem_we=%b required 0", mem_we);
    end
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 19'd3210 || mem_wdata !== 4'hA) begin
      errors++;
      $display("FAIL single_write: we=%b addr=%0d data=%h required 1 3210 a", mem_we, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: we=%b busy=%b required 0 0", mem_we, busy);
    end
    exp_q.push_back({19'd3210, 4'hA});
    check_log("single");
  endtask

  task automatic test_clip();
    int xs[3] = '{-1, 640, 0};
    int ys[3] = '{0, 0, 480};
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(xs[i], ys[i], 4'h5);
      checks++;
      if (busy !== 1'b0 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL clip_busy%0d: busy=%b we=%b required 0 0", i, busy, mem_we);
      end
    end
    repeat (3) tick();
    checks++;
    if (clip_count !== EXP_CLIPS) begin
      errors++;
      $display("FAIL clip_count: got %0d required %0d", clip_count, EXP_CLIPS);
    end
    check_log("clip");
  endtask

  task automatic test_corners();
    mem_ack = 1'b1;
    send(639, 479, 4'h3);
    send(0, 0, 4'h9);
    repeat (4) tick();
    exp_q.push_back({19'd307199, 4'h3});
    exp_q.push_back({19'd0, 4'h9});
    check_log("corners");
  endtask

  task automatic test_back_to_back();
    int xs[6] = '{1, 2, 3, 4, 5, 6};
    int ys[6] = '{0, 0, 1, 2, 3, 4};
    int n;
    logic [ADDR_W-1:0] addrs[6] = '{19'd1, 19'd2, 19'd643, 19'd1284, 19'd1925, 19'd2566};
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) send(xs[i], ys[i], COLOR_W'(i + 1));
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: ready/we/busy=%b required 011", {in_ready, mem_we, busy});
    end
    in_valid = 1'b1;
    in_x = xs[5];
    in_y = ys[5];
    in_color = 4'd6;
    repeat (3) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || mem_addr !== addrs[0] || mem_wdata !== 4'd1) begin
        errors++;
        $display("FAIL bp_hold: ready=%b addr=%0d data=%h required 0 %0d 1", in_ready, mem_addr, mem_wdata, addrs[0]);
      end
    end
    mem_ack = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL bp_ready_return: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: busy=%b we=%b required 0 0", busy, mem_we);
    end
    for (int i = 0; i < 6; i++) exp_q.push_back({addrs[i], COLOR_W'(i + 1)});
    check_log("bp");
  endtask

  task automatic test_late_ack();
    mem_ack = 1'b0;
    send(7, 7, 4'hC);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 19'd4487 || mem_wdata !== 4'hC) begin
        errors++;
        $display("FAIL late_hold%0d: we=%b addr=%0d data=%h required 1 4487 c", i, mem_we, mem_addr, mem_wdata);
      end
      if (i < 2) tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL late_done: we=%b busy=%b required 0 0", mem_we, busy);
    end
    tick();
    exp_q.push_back({19'd4487, 4'hC});
    check_log("late");
  endtask

  task automatic test_reset_mid_write();
    mem_ack = 1'b0;
    send(20, 1, 4'h1);
    send(21, 1, 4'h2);
    send(22, 1, 4'h3);
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: mem_we=%b required 1", mem_we);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_we, busy, in_ready} !== 3'b000 || mem_addr !== '0) begin
      errors++;
      $display("FAIL midrst_async: we/busy/ready=%b addr=%0d required 000 0", {mem_we, busy, in_ready}, mem_addr);
    end
    tick();
    reset = 1'b0;
    mem_ack = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: in_ready=%b required 1", in_ready);
    end
    repeat (5) tick();
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stale: we=%b busy=%b required 0 0", mem_we, busy);
    end
    check_log("midrst");
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_color = '0;
    mem_ack = 1'b0;
    tick();
    test_reset();
    test_single();
    test_clip();
    test_corners();
    test_back_to_back();
    test_late_ack();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
